// File: rtl/segment_scan_ctrl.sv
`timescale 1ns/1ps
// segment_scan_ctrl
//   Time-multiplexed hex display scanner. Drives one of DIGITS hex nibbles at
//   a time onto a shared digit-index / nibble bus, holding each digit for
//   SCAN_DIV clocks. Supports per-digit enable, leading-zero suppression,
//   per-digit blink and a valid/ready load port whose data is double-buffered
//   and only committed at a frame boundary so a frame never mixes old and new
//   values.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-low
//   load_valid  load_data is offered
//   load_ready  pending buffer empty; load taken when load_valid && load_ready
//   load_data   packed digits, digit i = load_data[4*i +: 4]
//   digit_en    per-digit enable (live)
//   blank_lz    suppress leading zero digits (live)
//   blink_mask  digits hidden during blink phase 1 (live)
//   seg_an      index of the digit currently driven
//   seg_data    nibble for seg_an
//   seg_off     1 = no digit eligible, display dark
//   frame_done  1-cycle pulse after each frame-boundary tick
module segment_scan_ctrl #(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 250000,
  parameter int BLINK_DIV = 50000000,
  localparam int AN_W     = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [AN_W-1:0]       seg_an,
  output logic [3:0]            seg_data,
  output logic                  seg_off,
  output logic                  frame_done
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  // Leading-zero mask: digits from the top down that are zero, stopping at
  // the first nonzero digit. Digit 0 is always kept so a value of zero still
  // shows a single "0".
  function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] data);
    logic [DIGITS-1:0] m;
    logic              run;
    m   = {DIGITS{1'b0}};
    run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (run && (data[4*i +: 4] == 4'h0)) begin
        m[i] = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
    return m;
  endfunction

  // Lowest set bit of e at an index >= lo. Returns {found, index}.
  function automatic logic [AN_W:0] first_from(input logic [DIGITS-1:0] e, input int lo);
    logic [AN_W:0] r;
    r = {(AN_W + 1){1'b0}};
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if ((i >= lo) && e[i]) begin
        r = {1'b1, AN_W'(i)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  logic [SCAN_W-1:0]   scan_cnt_r;
  logic [BLINK_W-1:0]  blink_cnt_r;
  logic                blink_ph_r;
  logic [AN_W-1:0]     idx_r;
  logic [4*DIGITS-1:0] active_r;
  logic [4*DIGITS-1:0] pend_r;

  logic                tick_s;
  logic [DIGITS-1:0]   blink_hide_s;
  logic [DIGITS-1:0]   elig_act_s;
  logic [DIGITS-1:0]   elig_pend_s;
  logic [DIGITS-1:0]   elig_new_s;
  logic [AN_W:0]       above_s;
  logic [AN_W:0]       low_new_s;
  logic                boundary_s;
  logic                commit_s;
  logic [4*DIGITS-1:0] new_active_s;
  logic [AN_W-1:0]     nxt_s;
  logic                none_s;
  logic [3:0]          nib_s;

  // Next-digit selection. The frame boundary is decided with the data
  // currently shown; when that boundary also commits the pending buffer, the
  // first digit of the new frame is picked with the committed data's
  // leading-zero mask so the new frame starts on the right digit.
  always_comb begin
    tick_s       = (scan_cnt_r == SCAN_W'(SCAN_DIV - 1));
    blink_hide_s = blink_ph_r ? blink_mask : {DIGITS{1'b0}};
    elig_act_s   = digit_en & ~blink_hide_s & ~(blank_lz ? lz_mask(active_r) : {DIGITS{1'b0}});
    elig_pend_s  = digit_en & ~blink_hide_s & ~(blank_lz ? lz_mask(pend_r) : {DIGITS{1'b0}});
    above_s      = first_from(elig_act_s, int'(idx_r) + 32'sd1);
    // No eligible digit above idx means a wrap; an empty mask also lands here.
    boundary_s   = ~above_s[AN_W];
    commit_s     = boundary_s & ~load_ready;
    new_active_s = commit_s ? pend_r : active_r;
    elig_new_s   = commit_s ? elig_pend_s : elig_act_s;
    low_new_s    = first_from(elig_new_s, 32'sd0);
    nxt_s        = above_s[AN_W] ? above_s[AN_W-1:0] : low_new_s[AN_W-1:0];
    none_s       = ~low_new_s[AN_W];
    nib_s        = new_active_s[{nxt_s, 2'b00} +: 4];
  end

  // Scan/blink timing, load buffering, commit and registered display outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_cnt_r  <= {SCAN_W{1'b0}};
      blink_cnt_r <= {BLINK_W{1'b0}};
      blink_ph_r  <= 1'b0;
      idx_r       <= {AN_W{1'b0}};
      active_r    <= {(4*DIGITS){1'b0}};
      pend_r      <= {(4*DIGITS){1'b0}};
      load_ready  <= 1'b1;
      seg_an      <= {AN_W{1'b0}};
      seg_data    <= 4'h0;
      seg_off     <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      scan_cnt_r <= tick_s ? {SCAN_W{1'b0}} : scan_cnt_r + 1'b1;

      if (blink_cnt_r == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_r <= {BLINK_W{1'b0}};
        blink_ph_r  <= ~blink_ph_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + 1'b1;
      end

      // Accept and commit are exclusive: accept needs an empty buffer,
      // commit needs a full one.
      if (load_valid && load_ready) begin
        pend_r     <= load_data;
        load_ready <= 1'b0;
      end else if (tick_s && commit_s) begin
        active_r   <= pend_r;
        load_ready <= 1'b1;
      end else begin
        load_ready <= load_ready;
      end

      if (tick_s) begin
        frame_done <= boundary_s;
        if (none_s) begin
          seg_off <= 1'b1;
        end else begin
          idx_r    <= nxt_s;
          seg_an   <= nxt_s;
          seg_data <= nib_s;
          seg_off  <= 1'b0;
        end
      end else begin
        seg_off <= seg_off;
      end
    end
  end

endmodule

// File: tb/tb_segment_scan_ctrl.sv
`timescale 1ns/1ps
// Directed bench for segment_scan_ctrl with DIGITS=8, SCAN_DIV=4, BLINK_DIV=64.
// Timeline after reset release: "edge n" is the n-th rising edge; ticks update
// outputs at edges 4,8,12,...; blink phase 1 holds after edges 64..127.
module tb_segment_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic [7:0]  digit_en;
  logic        blank_lz;
  logic [7:0]  blink_mask;
  logic [2:0]  seg_an;
  logic [3:0]  seg_data;
  logic        seg_off;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  segment_scan_ctrl #(.DIGITS(8), .SCAN_DIV(4), .BLINK_DIV(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .digit_en   (digit_en),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .seg_an     (seg_an),
    .seg_data   (seg_data),
    .seg_off    (seg_off),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"},    seg_an,     32'd0);
    check({tag, "_data"},  seg_data,   32'd0);
    check({tag, "_off"},   seg_off,    32'd0);
    check({tag, "_fd"},    frame_done, 32'd0);
    check({tag, "_ready"}, load_ready, 32'd1);
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    load_valid = 1'b0;
    step();
    step();
    check_reset_outputs("rst");
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic load_one(input logic [31:0] d);
    load_data  = d;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  logic [3:0] t1_data [8] = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 4'h2};
  int zeros;

  initial begin
    load_data  = 32'h0;
    digit_en   = 8'hFF;
    blank_lz   = 1'b0;
    blink_mask = 8'h00;

    // 1: full 8-digit scan after commit
    do_reset();
    load_one(32'h23000020);
    check("t1_ready_low", load_ready, 32'd0);
    step_to(31);
    check("t1_pre_an", seg_an, 32'd7);
    check("t1_pre_data", seg_data, 32'd0);
    for (int j = 0; j < 8; j++) begin
      step_to(32 + 4*j);
      check("t1_an", seg_an, j);
      check("t1_data", seg_data, t1_data[j]);
      check("t1_fd", frame_done, (j == 0) ? 32'd1 : 32'd0);
      if (j == 0) check("t1_ready_back", load_ready, 32'd1);
      step_to(35 + 4*j);
      check("t1_hold_an", seg_an, j);
    end
    step_to(64);
    check("t1_fd_period", frame_done, 32'd1);
    check("t1_wrap_an", seg_an, 32'd0);

    // 2: leading-zero suppression shrinks the frame to digits 0..2
    blank_lz = 1'b1;
    load_one(32'h00000120);
    step_to(92);
    check("t2_old_an", seg_an, 32'd7);
    check("t2_old_data", seg_data, 32'd2);
    step_to(96);
    check("t2_commit_fd", frame_done, 32'd1);
    check("t2_d0", seg_data, 32'd0);
    step_to(100);
    check("t2_an1", seg_an, 32'd1);
    check("t2_d1", seg_data, 32'd2);
    step_to(104);
    check("t2_an2", seg_an, 32'd2);
    check("t2_d2", seg_data, 32'd1);
    step_to(106);
    check("t2_fd_low", frame_done, 32'd0);
    step_to(108);
    check("t2_wrap_an", seg_an, 32'd0);
    check("t2_fd_12", frame_done, 32'd1);
    step_to(120);
    check("t2_fd_24", frame_done, 32'd1);

    // 3: second load refused while the first is pending
    step_to(124);
    load_data  = 32'h76543210;
    load_valid = 1'b1;
    step();
    check("t3_ready_low", load_ready, 32'd0);
    load_data = 32'hFEDCBA98;
    step_to(128);
    check("t3_ready_low2", load_ready, 32'd0);
    step_to(131);
    check("t3_old_an", seg_an, 32'd2);
    check("t3_old_data", seg_data, 32'd1);
    step_to(132);
    load_valid = 1'b0;
    check("t3_ready_back", load_ready, 32'd1);
    check("t3_fd", frame_done, 32'd1);
    check("t3_an0", seg_an, 32'd0);
    check("t3_d0", seg_data, 32'd0);
    step_to(136);
    check("t3_d1", seg_data, 32'd1);
    step_to(160);
    check("t3_an7", seg_an, 32'd7);
    check("t3_d7", seg_data, 32'd7);
    step_to(164);
    check("t3_fd2", frame_done, 32'd1);
    step_to(168);
    check("t3_not_b", seg_data, 32'd1);
    check("t3_ready_idle", load_ready, 32'd1);

    // 4: blink hides digit 0 during phase 1
    blank_lz   = 1'b0;
    blink_mask = 8'h01;
    do_reset();
    step_to(64);
    check("t4_ph0_an0", seg_an, 32'd0);
    zeros = 0;
    step_to(68);
    check("t4_ph1_an1", seg_an, 32'd1);
    while (cyc < 132) begin
      if (seg_an == 3'd0) zeros++;
      if (cyc == 96) begin
        check("t4_wrap_an", seg_an, 32'd1);
        check("t4_wrap_fd", frame_done, 32'd1);
      end
      step();
    end
    check("t4_hidden", zeros, 32'd0);
    step_to(152);
    check("t4_back_an", seg_an, 32'd0);
    check("t4_back_fd", frame_done, 32'd1);

    // 5: nothing enabled -> dark, boundary every tick, pending still commits
    digit_en   = 8'h00;
    blink_mask = 8'h00;
    do_reset();
    load_one(32'h000000A5);
    check("t5_ready_low", load_ready, 32'd0);
    step_to(3);
    check("t5_off_pre", seg_off, 32'd0);
    step_to(4);
    check("t5_off", seg_off, 32'd1);
    check("t5_fd", frame_done, 32'd1);
    check("t5_an_hold", seg_an, 32'd0);
    check("t5_data_hold", seg_data, 32'd0);
    check("t5_commit", load_ready, 32'd1);
    step_to(5);
    check("t5_fd_low", frame_done, 32'd0);
    step_to(8);
    check("t5_fd_4", frame_done, 32'd1);
    check("t5_off2", seg_off, 32'd1);
    digit_en = 8'h01;
    step_to(12);
    check("t5_on", seg_off, 32'd0);
    check("t5_single_an", seg_an, 32'd0);
    check("t5_single_data", seg_data, 32'd5);
    check("t5_single_fd", frame_done, 32'd1);
    step_to(16);
    check("t5_single_fd2", frame_done, 32'd1);

    // 6: reset mid-frame drops active and pending data
    digit_en = 8'hFF;
    do_reset();
    load_one(32'h89ABCDEF);
    step_to(32);
    check("t6_d0", seg_data, 32'hF);
    load_one(32'h11111111);
    check("t6_pend", load_ready, 32'd0);
    step_to(52);
    check("t6_an5", seg_an, 32'd5);
    check("t6_d5", seg_data, 32'hA);
    step_to(53);
    rst = 1'b0;
    step();
    check_reset_outputs("t6_rst");
    rst = 1'b1;
    cyc = 0;
    step_to(4);
    check("t6_an1", seg_an, 32'd1);
    check("t6_old_gone", seg_data, 32'd0);
    step_to(32);
    check("t6_fd", frame_done, 32'd1);
    check("t6_pend_gone", seg_data, 32'd0);
    check("t6_ready", load_ready, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
